// File: rtl/post_sparsity_pkg.sv
// ============================================================================
// Module   : post_sparsity_pkg
// Purpose  : Shared types and constants for the post-sparsity datapath.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package post_sparsity_pkg;

  localparam int IL   = 4;
  localparam int FL   = 16;
  localparam int N    = 16;
  localparam int IDXW = $clog2(N);

  typedef logic signed [IL+FL-1:0] fixed_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRAIN = 2'b01
  } ser_state_t;

  function automatic logic [IDXW:0] popcount(input logic [N-1:0] m);
    logic [IDXW:0] c;
    c = '0;
    for (int k = 0; k < N; k++) begin
      c = c + {{IDXW{1'b0}}, m[k]};
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serialize_output_if.sv
// ============================================================================
// Module   : serialize_output_if
// Purpose  : Sparse (index, value) stream with valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface serialize_output_if;
  import post_sparsity_pkg::*;

  fixed_t          o_val;
  logic [IDXW-1:0] o_idx;
  logic            o_valid;
  logic            o_ready;
  logic            o_last;

  modport master (output o_val, output o_idx, output o_valid, output o_last, input o_ready);
  modport slave  (input o_val, input o_idx, input o_valid, input o_last, output o_ready);

endinterface

`default_nettype wire

// File: rtl/lsb_index.sv
// ============================================================================
// Module   : lsb_index
// Purpose  : Lowest-set-bit priority encoder with any-set and single-set flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsb_index
  import post_sparsity_pkg::*;
(
  input  logic [N-1:0]    i_mask,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any,
  output logic            o_single
);

  // Scan downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_mask[k]) begin
        o_idx = IDXW'(k);
      end
    end
  end

  assign o_any    = |i_mask;
  assign o_single = o_any && ((i_mask & (i_mask - N'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/serialize_output.sv
// ============================================================================
// Module   : serialize_output
// Purpose  : Captures a lane vector and streams its nonzero lanes, lowest first.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serialize_output
  import post_sparsity_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  fixed_t                   i_im [N-1:0],
  input  logic                     output_ready,
  output logic                     output_taken,
  serialize_output_if.master       out_if,
  output logic                     o_all_zero,
  output logic [IDXW:0]            nnz,
  output logic [1:0]               state
);

  ser_state_t      r_state;
  fixed_t          r_buf [N-1:0];
  logic [N-1:0]    r_mask;
  logic            r_taken;
  logic            r_all_zero;
  logic [IDXW:0]   r_nnz;

  logic [N-1:0]    w_in_mask;
  logic [IDXW-1:0] w_idx;
  logic            w_any;
  logic            w_single;
  logic            w_valid;

  always_comb begin
    w_in_mask = '0;
    for (int k = 0; k < N; k++) begin
      w_in_mask[k] = (i_im[k] != '0);
    end
  end

  lsb_index u_lsb_index (
    .i_mask   (r_mask),
    .o_idx    (w_idx),
    .o_any    (w_any),
    .o_single (w_single)
  );

  assign w_valid = (r_state == DRAIN) && w_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_buf      <= '{default: '0};
      r_mask     <= '0;
      r_taken    <= 1'b0;
      r_all_zero <= 1'b0;
      r_nnz      <= '0;
    end else begin
      r_taken    <= 1'b0;
      r_all_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          // r_taken gates out the still-held output_ready of the vector just taken.
          if (output_ready && !r_taken) begin
            r_buf   <= i_im;
            r_mask  <= w_in_mask;
            r_nnz   <= popcount(w_in_mask);
            r_taken <= 1'b1;
            if (w_in_mask != '0) begin
              r_state <= DRAIN;
            end else begin
              r_all_zero <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!w_any) begin
            r_state <= IDLE;
          end else if (out_if.o_ready) begin
            r_mask[w_idx] <= 1'b0;
            if (w_single) begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_mask  <= '0;
        end
      endcase
    end
  end

  assign out_if.o_valid = w_valid;
  assign out_if.o_idx   = w_valid ? w_idx : '0;
  assign out_if.o_val   = w_valid ? r_buf[w_idx] : '0;
  assign out_if.o_last  = w_valid && w_single;

  assign output_taken = r_taken;
  assign o_all_zero   = r_all_zero;
  assign nnz          = r_nnz;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_serialize_output.sv
// ============================================================================
// Module   : tb_serialize_output
// Purpose  : Directed and random checks of serialize_output against a lane-list model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serialize_output;
  import post_sparsity_pkg::*;

  typedef struct {
    logic [IDXW-1:0] idx;
    fixed_t          val;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  fixed_t        im [N-1:0];
  logic          output_ready;
  logic          output_taken;
  logic          o_all_zero;
  logic [IDXW:0] nnz;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;

  beat_t  exp_q[$];
  fixed_t v_a  [N-1:0];
  fixed_t v_z  [N-1:0];
  fixed_t v_s  [N-1:0];
  fixed_t v_6a [N-1:0];
  fixed_t v_6b [N-1:0];
  fixed_t v_r  [N-1:0];

  serialize_output_if sif();

  serialize_output dut (
    .clk          (clk),
    .reset        (reset),
    .i_im         (im),
    .output_ready (output_ready),
    .output_taken (output_taken),
    .out_if       (sif),
    .o_all_zero   (o_all_zero),
    .nnz          (nnz),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the expected stream is simply the nonzero lanes in index order.
  task automatic load_model(input fixed_t v [N-1:0]);
    beat_t b;
    exp_q.delete();
    for (int j = 0; j < N; j++) begin
      if (v[j] != 0) begin
        b.idx = IDXW'(j);
        b.val = v[j];
        exp_q.push_back(b);
      end
    end
  endtask

  // Called at the negedge right after the capture edge; returns at the first IDLE negedge.
  task automatic drain(input fixed_t v [N-1:0], input int mode, input string tag);
    int   cyc;
    logic rdy;
    load_model(v);
    check({tag, ".taken"}, output_taken, 1);
    check({tag, ".nnz"}, nnz, exp_q.size());
    check({tag, ".allzero"}, o_all_zero, (exp_q.size() == 0));
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (cyc > 0) check({tag, ".taken_pulse"}, output_taken, 0);
      check({tag, ".valid"}, sif.o_valid, 1);
      check({tag, ".idx"}, sif.o_idx, exp_q[0].idx);
      check({tag, ".val"}, sif.o_val, exp_q[0].val);
      check({tag, ".last"}, sif.o_last, (exp_q.size() == 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sif.o_ready = rdy;
      if (rdy) void'(exp_q.pop_front());
      cyc++;
      @(negedge clk);
    end
    check({tag, ".beats_left"}, exp_q.size(), 0);
    check({tag, ".end_valid"}, sif.o_valid, 0);
    check({tag, ".end_last"}, sif.o_last, 0);
    check({tag, ".end_state"}, state, 0);
    if (cyc > 0) check({tag, ".end_taken"}, output_taken, 0);
  endtask

  task automatic send(input fixed_t v [N-1:0], input int mode, input string tag);
    im = v;
    output_ready = 1'b1;
    @(negedge clk);
    output_ready = 1'b0;
    drain(v, mode, tag);
  endtask

  initial begin
    reset        = 1'b1;
    output_ready = 1'b0;
    sif.o_ready  = 1'b0;
    for (int j = 0; j < N; j++) begin
      im[j]   = '0;
      v_a[j]  = fixed_t'(j + 1);
      v_z[j]  = '0;
      v_s[j]  = '0;
      v_6a[j] = fixed_t'(j + 1);
      v_6b[j] = '0;
    end
    v_a[5]  = '0;
    v_a[7]  = '0;
    v_a[8]  = '0;
    v_a[11] = '0;
    v_a[15] = '0;
    v_s[15] = 20'hFFFFF;
    v_6b[3] = fixed_t'(7);

    repeat (3) @(negedge clk);
    check("rst.state", state, 0);
    check("rst.valid", sif.o_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst.taken", output_taken, 0);
    check("rst.allzero", o_all_zero, 0);
    check("rst.last", sif.o_last, 0);
    check("rst.val", sif.o_val, 0);
    check("rst.idx", sif.o_idx, 0);
    check("rst.nnz", nnz, 0);

    send(v_a, 0, "s2");

    send(v_z, 0, "s3");
    @(negedge clk);
    check("s3.allzero_pulse", o_all_zero, 0);
    check("s3.taken_pulse", output_taken, 0);
    check("s3.valid", sif.o_valid, 0);
    check("s3.state", state, 0);

    send(v_a, 1, "s4");

    send(v_s, 0, "s5");

    // Back-to-back: output_ready stays high, second vector waits on the input.
    im = v_6a;
    output_ready = 1'b1;
    @(negedge clk);
    im = v_6b;
    drain(v_6a, 0, "s6a");
    @(negedge clk);
    output_ready = 1'b0;
    drain(v_6b, 0, "s6b");

    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < N; j++) begin
        v_r[j] = ($urandom_range(0, 2) == 0) ? '0 : fixed_t'($urandom);
      end
      send(v_r, 2, "rnd");
    end

    // Reset in the middle of a drain discards the rest of the vector.
    im = v_a;
    output_ready = 1'b1;
    @(negedge clk);
    output_ready = 1'b0;
    sif.o_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rstd.pre_valid", sif.o_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstd.valid", sif.o_valid, 0);
    check("rstd.state", state, 0);
    check("rstd.nnz", nnz, 0);
    check("rstd.taken", output_taken, 0);
    repeat (2) @(negedge clk);
    check("rstd.after_valid", sif.o_valid, 0);
    check("rstd.after_taken", output_taken, 0);
    check("rstd.after_state", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serialize_output.md
Name: serialize_output

Overview:
Consumer end of the update_output result handshake. It accepts a 16-lane fixed-point vector while upstream holds output_ready, and returns a one-cycle output_taken pulse. It then streams only the nonzero lanes, lowest index first, as (index, value) pairs over a valid/ready interface. It sits between update_output and the sparse write-back / accumulation path of the post-sparsity datapath.

Parameters:
IL, 4, integer bits of signed fixed-point lane value
FL, 16, fractional bits of signed fixed-point lane value
N, 16, lanes per vector (index width = $clog2(N) = 4)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
i_im  input  [IL+FL-1:0] x N (unpacked [N-1:0], signed)  result vector from update_output o_im
output_ready  input  1  upstream vector valid; held with i_im stable until output_taken seen
output_taken  output  1  one-cycle pulse, vector captured
o_val  output  [IL+FL-1:0] signed  current nonzero lane value
o_idx  output  4  lane index of o_val
o_valid  output  1  o_val/o_idx valid
o_ready  input  1  downstream accepts when o_valid & o_ready
o_last  output  1  current beat is final nonzero of vector
o_all_zero  output  1  one-cycle pulse: captured vector had no nonzero lanes
nnz  output  5  nonzero count of captured vector (0..16), held until next capture
state  output  2  FSM state (debug)

Behaviour:
- Reset: state=IDLE; buffer and mask cleared; output_taken=0, o_valid=0, o_last=0, o_all_zero=0, o_val=0, o_idx=0, nnz=0. Reset in DRAIN discards the vector: no further beats, no output_taken.
- FSM states: IDLE=2'b00, DRAIN=2'b01. Encodings 2'b10 and 2'b11 are illegal; the FSM recovers to IDLE from either.
- IDLE: on posedge with output_ready=1:
  - Capture all N lanes into the buffer.
  - mask[k] <= (i_im[k] != 0).
  - nnz <= popcount(mask).
  - output_taken <= 1 for exactly one cycle.
  - If mask != 0, go to DRAIN; otherwise stay in IDLE and pulse o_all_zero together with output_taken.
- Latency: capture at edge k; output_taken and the first o_valid are both high in the cycle after edge k.
- DRAIN: o_valid=1. o_idx = lowest set bit of mask. o_val = buffer[o_idx]. o_last=1 iff popcount(mask)==1.
  - On o_valid & o_ready: clear mask[o_idx] at the next edge; the next beat is presented the following cycle.
  - After the beat with o_last accepted, go to IDLE with o_valid=0 from the next cycle.
  - If o_ready=0: hold o_val, o_idx and o_last stable.
- Throughput: 1 beat/cycle with o_ready=1. Minimum gap between captures is nnz+1 cycles.
- output_ready is ignored in DRAIN and in the capture cycle. A new capture can occur in the first IDLE cycle after the last beat.
- Values are passed through bit-exact; no rounding or saturation. A lane counts as zero only when all IL+FL bits are 0, so negative values are nonzero.
- o_val, o_idx and o_last are driven from registered buffer and mask, with combinational selection only. Outputs are 0 when o_valid=0.

Decomposition:
- Package post_sparsity_pkg holds:
  - localparams IL, FL, N, IDXW.
  - typedef logic signed [IL+FL-1:0] fixed_t.
  - typedef enum logic [1:0] {IDLE, DRAIN} ser_state_t.
- Sub-module lsb_index: combinational priority encoder, N-bit mask to 4-bit index of lowest set bit plus an any-set flag. Also used for the o_last check via a mask & (mask-1) == 0 test.

Test Plan:
1. Reset → all outputs 0 and state=00. Assert reset mid-DRAIN → next cycle o_valid=0, state=00, buffer contents discarded.
2. i_im[j]=j+1 with lanes 5,7,8,11,15 zeroed, output_ready pulsed 1 cycle, o_ready=1:
   - output_taken pulses once; nnz=11.
   - Beats (idx:val) 0:1, 1:2, 2:3, 3:4, 4:5, 6:7, 9:10, 10:11, 12:13, 13:14, 14:15 on 11 consecutive cycles.
   - o_last only on idx 14; then state=00.
3. All-zero vector with output_ready=1 → output_taken and o_all_zero pulse together, nnz=0, no o_valid, state stays 00.
4. Same vector as scenario 2 with o_ready toggled 1,0,0,1,… → no beat lost or duplicated; o_val/o_idx stable while stalled; 11 beats total.
5. Single nonzero lane i_im[15]=20'hFFFFF (-1 LSB) → one beat, idx=15, val=20'hFFFFF, o_last=1 on the first beat.
6. output_ready held high across two back-to-back vectors ([1..16] then a vector with only lane 3=7) → second capture occurs on the cycle after the 16th beat; second vector yields beat 3:7 with o_last=1.
